// File: rtl/frogger_config_loader.sv
// Loads a byte stream into the Frogger game's 32x8 register port, then reads every
// entry back and compares the write and read checksums to verify the load.
//
// state      | meaning
// IDLE       | waiting for i_Start; checksum and error held
// WRITE      | accepting source bytes, one register write per byte
// GAP        | final write strobe in flight; address counter cleared
// READ_ISSUE | read strobe for entry count
// READ_WAIT  | waiting out the game's read latency, then accumulating the data
// CHECK      | compare sums; pulse done or set error
module frogger_config_loader #(
  parameter int C_NUM_ENTRIES  = 32,
  parameter int C_READ_LATENCY = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Data_Valid,
  input  logic [7:0] i_Data,
  output logic       o_Data_Ready,
  output logic       o_write_en,
  output logic [4:0] o_write_addr,
  output logic [7:0] o_write_data,
  output logic       o_read_en,
  output logic [4:0] o_read_addr,
  input  logic [7:0] i_read_data,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Error,
  output logic [7:0] o_Checksum
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    GAP        = 3'd2,
    READ_ISSUE = 3'd3,
    READ_WAIT  = 3'd4,
    CHECK      = 3'd5
  } state_t;

  localparam logic [5:0] LAST_ENTRY = 6'(C_NUM_ENTRIES - 1);
  localparam logic [1:0] LAT_LOAD   = 2'(C_READ_LATENCY - 1);

  state_t      state, state_next;
  logic [5:0]  count;
  logic [1:0]  lat_cnt;
  logic [7:0]  write_sum;
  logic [7:0]  read_sum;
  logic        handshake;
  logic        last_entry;
  logic        lat_done;

  assign handshake  = (state == WRITE) && i_Data_Valid;
  assign last_entry = (count == LAST_ENTRY);
  assign lat_done   = (lat_cnt == 2'd0);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (i_Start) state_next = WRITE;
      WRITE:      if (handshake && last_entry) state_next = GAP;
      GAP:        state_next = READ_ISSUE;
      READ_ISSUE: state_next = READ_WAIT;
      READ_WAIT:  if (lat_done) state_next = last_entry ? CHECK : READ_ISSUE;
      CHECK:      state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Write strobe is registered from the handshake; read side is a down-counted wait.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count        <= '0;
      lat_cnt      <= '0;
      write_sum    <= '0;
      read_sum     <= '0;
      o_write_en   <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
      o_Error      <= 1'b0;
    end else begin
      o_write_en <= handshake;
      if (handshake) begin
        o_write_addr <= count[4:0];
        o_write_data <= i_Data;
        write_sum    <= write_sum + i_Data;
        count        <= count + 6'd1;
      end
      case (state)
        IDLE: begin
          if (i_Start) begin
            count     <= '0;
            write_sum <= '0;
            read_sum  <= '0;
            o_Error   <= 1'b0;
          end
        end
        GAP:        count   <= '0;
        READ_ISSUE: lat_cnt <= LAT_LOAD;
        READ_WAIT: begin
          if (lat_done) begin
            read_sum <= read_sum + i_read_data;
            if (!last_entry) count <= count + 6'd1;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        CHECK: if (write_sum != read_sum) o_Error <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_Data_Ready = (state == WRITE);
  assign o_read_en    = (state == READ_ISSUE);
  assign o_read_addr  = count[4:0];
  assign o_Busy       = (state != IDLE);
  assign o_Done       = (state == CHECK) && (write_sum == read_sum);
  assign o_Checksum   = write_sum;

endmodule

// File: tb/tb_frogger_config_loader.sv
// Scoreboard bench for frogger_config_loader: two instances (32 entries / latency 1 and
// 4 entries / latency 3) driven in turn against a game register-file model.
module tb_frogger_config_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start [2];
  logic       valid [2];
  logic [7:0] data  [2];
  logic       ready [2];
  logic       we    [2];
  logic [4:0] waddr [2];
  logic [7:0] wdata [2];
  logic       re    [2];
  logic [4:0] raddr [2];
  logic [7:0] rdata [2];
  logic       busy  [2];
  logic       done  [2];
  logic       err   [2];
  logic [7:0] csum  [2];
  logic       corrupt [2];

  frogger_config_loader #(.C_NUM_ENTRIES(32), .C_READ_LATENCY(1)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start[0]), .i_Data_Valid(valid[0]),
    .i_Data(data[0]), .o_Data_Ready(ready[0]), .o_write_en(we[0]),
    .o_write_addr(waddr[0]), .o_write_data(wdata[0]), .o_read_en(re[0]),
    .o_read_addr(raddr[0]), .i_read_data(rdata[0]), .o_Busy(busy[0]),
    .o_Done(done[0]), .o_Error(err[0]), .o_Checksum(csum[0]));

  frogger_config_loader #(.C_NUM_ENTRIES(4), .C_READ_LATENCY(3)) u_dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start[1]), .i_Data_Valid(valid[1]),
    .i_Data(data[1]), .o_Data_Ready(ready[1]), .o_write_en(we[1]),
    .o_write_addr(waddr[1]), .o_write_data(wdata[1]), .o_read_en(re[1]),
    .o_read_addr(raddr[1]), .i_read_data(rdata[1]), .o_Busy(busy[1]),
    .o_Done(done[1]), .o_Error(err[1]), .o_Checksum(csum[1]));

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Game register file: read data appears lat_of(u) cycles after the address.
  logic [7:0] mem  [2][32];
  logic [7:0] pipe [2][3];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (we[u]) mem[u][waddr[u]] <= wdata[u];
      pipe[u][0] <= (corrupt[u] && raddr[u] == 5'd5) ? 8'h55 : mem[u][raddr[u]];
      pipe[u][1] <= pipe[u][0];
      pipe[u][2] <= pipe[u][1];
    end
  end
  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];

  typedef struct packed {logic [4:0] addr; logic [7:0] data; logic [7:0] csum;} wr_t;
  typedef struct packed {logic ok; logic [7:0] csum; int lat;} res_t;
  wr_t        wq[$];
  logic [4:0] rq[$];
  res_t       resq[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int last_re [2];
  bit prev_err [2];
  bit chk_busy [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    wr_t        e;
    res_t       r;
    logic [4:0] a;
    if (!rst_n) begin
      prev_err = '{0, 0};
      chk_busy = '{0, 0};
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (chk_busy[u]) begin
          check("busy_falls_after_done", 32'(busy[u]), 32'd0);
          chk_busy[u] = 0;
        end
        if (we[u] || re[u]) check("strobe_exclusive", 32'(we[u] & re[u]), 32'd0);
        if (we[u]) begin
          if (wq.size() == 0) check("unexpected_write_addr", 32'(waddr[u]), 32'hFFFF_FFFF);
          else begin
            e = wq.pop_front();
            check("write_addr", 32'(waddr[u]), 32'(e.addr));
            check("write_data", 32'(wdata[u]), 32'(e.data));
            check("running_checksum", 32'(csum[u]), 32'(e.csum));
          end
        end
        if (re[u]) begin
          if (rq.size() == 0) check("unexpected_read_addr", 32'(raddr[u]), 32'hFFFF_FFFF);
          else begin
            a = rq.pop_front();
            check("read_addr", 32'(raddr[u]), 32'(a));
          end
          if (raddr[u] != 5'd0)
            check("read_spacing", 32'(cyc - last_re[u]), 32'(1 + lat_of(u)));
          last_re[u] = cyc;
        end
        if (done[u] || (err[u] && !prev_err[u])) begin
          if (resq.size() == 0) check("unexpected_result_done", 32'(done[u]), 32'd2);
          else begin
            r = resq.pop_front();
            check("outcome_done", 32'(done[u]), 32'(r.ok));
            check("outcome_error", 32'(err[u]), 32'(!r.ok));
            check("final_checksum", 32'(csum[u]), 32'(r.csum));
            check("all_reads_seen", 32'(rq.size()), 32'd0);
            if (done[u] && r.lat >= 0) check("load_latency", 32'(cyc - start_cyc), 32'(r.lat));
          end
          if (done[u]) chk_busy[u] = 1;
        end
        prev_err[u] = err[u];
      end
    end
  end

  task automatic wait_idle(input int u);
    bit got = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (!busy[u]) begin
        got = 1;
        break;
      end
    end
    if (!got) check("idle_timeout", 32'(busy[u]), 32'd0);
    repeat (2) @(negedge clk);
    check("result_consumed", 32'(resq.size()), 32'd0);
  endtask

  task automatic send_byte(input int u, input logic [7:0] d, input logic [4:0] addr,
                           input logic [7:0] run_sum, input bit busy_start);
    bit got = 0;
    valid[u] = 1'b1;
    data[u]  = d;
    if (busy_start) start[u] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready[u]) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ready_timeout", 32'(ready[u]), 32'd1);
    else wq.push_back('{addr: addr, data: d, csum: run_sum});
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 three idle cycles after every 4th byte, 2 random idles
  task automatic do_load(input int u, input logic [7:0] b[$], input int gap_mode,
                         input int busy_at, input bit corrupt_en, input int abort_after);
    int n = b.size();
    int k;
    logic [7:0] sum = 8'h00;
    logic [7:0] rb;
    corrupt[u] = corrupt_en;
    @(posedge clk); #1;
    start[u] = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start[u] = 1'b0;
    check("start_clears_checksum", 32'(csum[u]), 32'd0);
    check("start_clears_error", 32'(err[u]), 32'd0);
    check("busy_in_load", 32'(busy[u]), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (abort_after >= 0 && i == abort_after) break;
      if (gap_mode == 1) k = (i > 0 && i % 4 == 0) ? 3 : 0;
      else if (gap_mode == 2) k = $urandom_range(0, 2);
      else k = 0;
      valid[u] = 1'b0;
      repeat (k) begin @(posedge clk); #1; end
      sum = sum + b[i];
      send_byte(u, b[i], 5'(i), sum, i == busy_at);
    end
    valid[u] = 1'b0;
    if (abort_after >= 0) return;
    for (int i = 0; i < n; i++) rq.push_back(5'(i));
    rb = sum;
    if (corrupt_en && n > 5) rb = sum - b[5] + 8'h55;
    resq.push_back('{ok: (rb == sum), csum: sum,
                     lat: (gap_mode == 0) ? n + 2 + n * (1 + lat_of(u)) : -1});
    wait_idle(u);
  endtask

  task automatic check_all_zero(input int u, input string tag);
    check({tag, "_ready"}, 32'(ready[u]), 32'd0);
    check({tag, "_write_en"}, 32'(we[u]), 32'd0);
    check({tag, "_write_addr"}, 32'(waddr[u]), 32'd0);
    check({tag, "_write_data"}, 32'(wdata[u]), 32'd0);
    check({tag, "_read_en"}, 32'(re[u]), 32'd0);
    check({tag, "_read_addr"}, 32'(raddr[u]), 32'd0);
    check({tag, "_busy"}, 32'(busy[u]), 32'd0);
    check({tag, "_done"}, 32'(done[u]), 32'd0);
    check({tag, "_error"}, 32'(err[u]), 32'd0);
    check({tag, "_checksum"}, 32'(csum[u]), 32'd0);
  endtask

  logic [7:0] ramp[$];
  logic [7:0] bq[$];

  initial begin
    for (int u = 0; u < 2; u++) begin
      start[u] = 0; valid[u] = 0; data[u] = 0; corrupt[u] = 0; last_re[u] = 0;
    end
    for (int i = 0; i < 32; i++) ramp.push_back(8'(i));
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(0, "reset0");
    check_all_zero(1, "reset1");
    rst_n = 1'b1;

    // source bytes offered while idle must be ignored
    valid[0] = 1'b1; data[0] = 8'hAA;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("idle_not_ready", 32'(ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    valid[0] = 1'b0;

    do_load(0, ramp, 0, -1, 0, -1);           // clean load, checksum 0xF0
    do_load(0, ramp, 1, -1, 0, -1);           // backpressure gaps
    do_load(0, ramp, 0, -1, 1, -1);           // corrupted readback at address 5
    repeat (3) @(negedge clk);
    check("error_sticky_idle", 32'(err[0]), 32'd1);
    check("error_idle_not_busy", 32'(busy[0]), 32'd0);
    check("checksum_held_idle", 32'(csum[0]), 32'hF0);
    do_load(0, ramp, 0, 10, 0, -1);           // start while busy at byte 10

    bq.delete();
    for (int i = 0; i < 32; i++) bq.push_back(8'($urandom));
    do_load(0, bq, 0, -1, 0, 12);             // abandoned after 12 bytes
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("writes_seen_before_reset", 32'(wq.size()), 32'd0);
    check_all_zero(0, "async_reset");
    wq.delete(); rq.delete(); resq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_load(0, bq, 0, -1, 0, -1);             // fresh load from address 0

    for (int r = 0; r < 3; r++) begin
      bq.delete();
      for (int i = 0; i < 32; i++) bq.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) bq[5] = 8'h55;
      do_load(0, bq, 2, -1, 1'($urandom_range(0, 1)), -1);
    end

    bq = '{8'hFF, 8'h01, 8'h10, 8'h20};
    do_load(1, bq, 0, -1, 0, -1);             // 4 entries, latency 3, checksum 0x30
    check("variant_checksum", 32'(csum[1]), 32'h30);
    for (int r = 0; r < 2; r++) begin
      bq.delete();
      for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
      do_load(1, bq, 2, -1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frogger_config_loader.md
Name: frogger_config_loader

Overview:
- Initiator for the game core's 32x8 register port (i_write_en / i_write_addr / i_write_data / i_read_en / i_read_addr / o_read_data on the game side).
- Accepts a byte stream over a valid/ready source, such as a UART receiver or a test host.
- Writes the bytes to consecutive register addresses, then reads every entry back and compares checksums to verify the load.
- Sits between the byte source and the Frogger game top; reports busy/done/error status.

Parameters:
- C_NUM_ENTRIES, 32, number of registers to load; addresses 0..C_NUM_ENTRIES-1; legal range 1..32.
- C_READ_LATENCY, 1, cycles from read-enable/address to valid game o_read_data; legal range 1..3.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Start  in  1  single-cycle start pulse; honoured only in IDLE.
- i_Data_Valid  in  1  source byte valid.
- i_Data  in  8  source byte.
- o_Data_Ready  out  1  loader can accept a byte.
- o_write_en  out  1  write strobe to game i_write_en.
- o_write_addr  out  5  to game i_write_addr.
- o_write_data  out  8  to game i_write_data.
- o_read_en  out  1  read strobe to game i_read_en.
- o_read_addr  out  5  to game i_read_addr.
- i_read_data  in  8  from game o_read_data.
- o_Busy  out  1  high in any state other than IDLE.
- o_Done  out  1  one-cycle pulse when verify passes.
- o_Error  out  1  sticky verify failure; cleared by the next accepted i_Start.
- o_Checksum  out  8  mod-256 sum of written bytes; held after the load.

Behaviour:
- Reset (async, i_Rst_L=0):
  - State returns to IDLE.
  - All outputs 0, including o_Checksum and o_Error.
  - Internal counters and sums are 0.
  - Reset mid-load abandons the load immediately; no further strobes are issued.
- States: IDLE, WRITE, GAP, READ_ISSUE, READ_WAIT, CHECK.
- IDLE:
  - i_Start=1 moves to WRITE next cycle.
  - Entering WRITE clears the address counter, the write sum, the read sum and o_Error.
- WRITE:
  - o_Data_Ready=1 is decoded from the state register; it is 0 in every other state.
  - Handshake occurs when i_Data_Valid && o_Data_Ready.
  - On a handshake, the next cycle drives o_write_en=1, o_write_addr=count, o_write_data=i_Data.
  - On a handshake, the write sum adds i_Data mod 256 and count increments.
  - With no handshake, o_write_en=0 next cycle, and o_write_addr/o_write_data hold their last values.
  - The handshake on count=C_NUM_ENTRIES-1 moves the state to GAP; o_Data_Ready is 0 from the next cycle.
- GAP:
  - Lasts exactly one cycle, during which the final write strobe is issued.
  - Clears the count, then moves to READ_ISSUE.
- READ_ISSUE:
  - o_read_en=1 for one cycle with o_read_addr=count, then moves to READ_WAIT.
- READ_WAIT:
  - Waits C_READ_LATENCY cycles after the strobe, then samples i_read_data.
  - Sampled data adds to the read sum mod 256.
  - If count=C_NUM_ENTRIES-1, moves to CHECK; otherwise count increments and the state returns to READ_ISSUE.
  - Each entry costs 1+C_READ_LATENCY cycles; there is no pipelined overlap.
- CHECK (one cycle):
  - Sums equal: o_Done=1 for that cycle, then IDLE.
  - Sums differ: o_Error=1, held until the next accepted i_Start, then IDLE.
- o_Checksum:
  - Updates with the write sum as each byte is accepted.
  - Holds its final value in IDLE until the next accepted i_Start clears it.
- Strobe exclusivity:
  - o_write_en and o_read_en are never high in the same cycle.
  - Each strobe is a single-cycle pulse per entry.
- i_Start while o_Busy=1 is ignored, with no state change.
- i_Data_Valid outside WRITE is ignored; no byte is consumed.
- Address width rules:
  - o_write_addr and o_read_addr are the 5 LSBs of count.
  - count is 6 bits, so C_NUM_ENTRIES=32 ends at address 31 without wrapping.
- Total latency, back-to-back source with C_READ_LATENCY=1: start + C_NUM_ENTRIES write cycles + 1 gap + 2*C_NUM_ENTRIES read cycles + 1 check.

Test Plan:
1. Clean load:
   - Stimulus: defaults; i_Start; 32 back-to-back bytes 0x00..0x1F.
   - Required response: 32 write strobes with addr=data=i; then 32 read strobes addr 0..31; model returns the stored values; o_Checksum=0xF0; o_Done pulses once; o_Error=0; o_Busy falls the cycle after o_Done.
2. Backpressure gaps:
   - Stimulus: source drops i_Data_Valid for 3 cycles after every 4th byte.
   - Required response: no write strobe during gaps; addresses remain strictly sequential; result identical to scenario 1.
3. Corrupted readback:
   - Stimulus: model returns 0x55 instead of 0x05 at address 5.
   - Required response: no o_Done; o_Error=1 after CHECK, holding through IDLE; next i_Start clears it the following cycle.
4. Start while busy:
   - Stimulus: second i_Start mid-WRITE at byte 10.
   - Required response: ignored; addresses continue from 10; completes normally.
5. Reset mid-load:
   - Stimulus: assert i_Rst_L=0 asynchronously after 12 bytes.
   - Required response: all outputs 0 immediately, without waiting for a clock edge; after release, a fresh i_Start restarts at address 0 with o_Checksum=0.
6. Parameter variant:
   - Stimulus: C_NUM_ENTRIES=4, C_READ_LATENCY=3; bytes 0xFF,0x01,0x10,0x20.
   - Required response: o_Checksum=0x30 (sum wraps mod 256); read strobes spaced 4 cycles apart; o_Done pulses.
